// File: rtl/ex_muldiv.sv
// ex_muldiv: execute stage with single-cycle ALU, EX/MEM and WB operand
// forwarding, and an iterative radix-2 multiply/divide engine (RV32M/RV64M).
// Optional build macro EX_FASTMUL_EN: MUL/MULH/MULHSU/MULHU become single-cycle
// combinational multiplies and the iterative engine serves divide/remainder only.
module ex_muldiv #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALUSEL_W  = 5,
  parameter int unsigned REGADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [ALUSEL_W-1:0]  alusel,
  input  logic [XLEN-1:0]      s1data,
  input  logic [XLEN-1:0]      s2data,
  input  logic                 fromreg1,
  input  logic                 fromreg2,
  input  logic [REGADDR_W-1:0] reg1addr,
  input  logic [REGADDR_W-1:0] reg2addr,
  input  logic [REGADDR_W-1:0] rd,
  input  logic                 regwe,
  input  logic [REGADDR_W-1:0] ex_mem_rd,
  input  logic                 ex_mem_regwe,
  input  logic [XLEN-1:0]      ex_mem_wbdata,
  input  logic [REGADDR_W-1:0] wb_rd,
  input  logic                 wb_regwe,
  input  logic [XLEN-1:0]      wb_wbdata,
  output logic                 stallreq,
  output logic                 out_valid,
  output logic [REGADDR_W-1:0] rd_o,
  output logic                 regwe_o,
  output logic [XLEN-1:0]      result,
  output logic                 busy,
  output logic [XLEN-1:0]      s1data_n,
  output logic [XLEN-1:0]      s2data_n
);

  localparam int unsigned SHAMT_W = $clog2(XLEN);
  localparam int unsigned CNT_W   = $clog2(XLEN + 1);
  localparam int unsigned PROD_W  = 2 * XLEN;

  localparam logic [ALUSEL_W-1:0] OP_ADD    = ALUSEL_W'(0);
  localparam logic [ALUSEL_W-1:0] OP_SUB    = ALUSEL_W'(1);
  localparam logic [ALUSEL_W-1:0] OP_SLL    = ALUSEL_W'(2);
  localparam logic [ALUSEL_W-1:0] OP_SRL    = ALUSEL_W'(3);
  localparam logic [ALUSEL_W-1:0] OP_SRA    = ALUSEL_W'(4);
  localparam logic [ALUSEL_W-1:0] OP_XOR    = ALUSEL_W'(5);
  localparam logic [ALUSEL_W-1:0] OP_OR     = ALUSEL_W'(6);
  localparam logic [ALUSEL_W-1:0] OP_AND    = ALUSEL_W'(7);
  localparam logic [ALUSEL_W-1:0] OP_ULT    = ALUSEL_W'(8);
  localparam logic [ALUSEL_W-1:0] OP_SLT    = ALUSEL_W'(9);
  localparam logic [ALUSEL_W-1:0] OP_MUL    = ALUSEL_W'(10);
  localparam logic [ALUSEL_W-1:0] OP_MULH   = ALUSEL_W'(11);
  localparam logic [ALUSEL_W-1:0] OP_MULHSU = ALUSEL_W'(12);
  localparam logic [ALUSEL_W-1:0] OP_MULHU  = ALUSEL_W'(13);
  localparam logic [ALUSEL_W-1:0] OP_DIV    = ALUSEL_W'(14);
  localparam logic [ALUSEL_W-1:0] OP_DIVU   = ALUSEL_W'(15);
  localparam logic [ALUSEL_W-1:0] OP_REM    = ALUSEL_W'(16);
  localparam logic [ALUSEL_W-1:0] OP_REMU   = ALUSEL_W'(17);

  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [XLEN-1:0]       acc_q, acc_d;   // remainder / product high half
  logic [XLEN-1:0]       lo_q, lo_d;     // quotient / multiplier, product low half
  logic [XLEN-1:0]       opb_q, opb_d;   // divisor / multiplicand magnitude
  logic [ALUSEL_W-1:0]   op_q, op_d;
  logic [REGADDR_W-1:0]  rd_q, rd_d;
  logic                  regwe_q, regwe_d;
  logic                  neg_q, neg_d;

  logic                  sa_c, sb_c, is_md_c, div_zero_c, div_ovf_c, neg_start_c, is_div_q_c, ge_c;
  logic [XLEN-1:0]       abs_a_c, abs_b_c, alu_c, md_res_c;
  logic [XLEN:0]         mul_sum_c, rem_sh_c;
  logic [PROD_W-1:0]     prod_fix_c;
  logic [SHAMT_W-1:0]    shamt_c;

  // Operand forwarding: EX/MEM has priority over WB; x0 never forwards
  always_comb begin
    s1data_n = s1data;
    s2data_n = s2data;
    if (fromreg1 && reg1addr != '0 && ex_mem_regwe && ex_mem_rd == reg1addr) s1data_n = ex_mem_wbdata;
    else if (fromreg1 && reg1addr != '0 && wb_regwe && wb_rd == reg1addr)    s1data_n = wb_wbdata;
    if (fromreg2 && reg2addr != '0 && ex_mem_regwe && ex_mem_rd == reg2addr) s2data_n = ex_mem_wbdata;
    else if (fromreg2 && reg2addr != '0 && wb_regwe && wb_rd == reg2addr)    s2data_n = wb_wbdata;
  end

  // Issue-time decode: sign handling, magnitudes and divide special cases
  always_comb begin
    sa_c        = s1data_n[XLEN-1] & (alusel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    sb_c        = s2data_n[XLEN-1] & (alusel inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
    abs_a_c     = sa_c ? -s1data_n : s1data_n;
    abs_b_c     = sb_c ? -s2data_n : s2data_n;
    neg_start_c = (alusel == OP_REM) ? sa_c : (sa_c ^ sb_c);
    div_zero_c  = (alusel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) && (s2data_n == '0);
    div_ovf_c   = (alusel inside {OP_DIV, OP_REM}) && (s1data_n == XMIN) && (s2data_n == '1);
`ifdef EX_FASTMUL_EN
    is_md_c     = alusel inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`else
    is_md_c     = alusel inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
`endif
  end

`ifdef EX_FASTMUL_EN
  logic [PROD_W-1:0] fm_a_c, fm_b_c, fm_prod_c;

  // Single-cycle multiplier on sign-extended (per op) operands
  always_comb begin
    fm_a_c    = {{XLEN{sa_c}}, s1data_n};
    fm_b_c    = {{XLEN{sb_c}}, s2data_n};
    fm_prod_c = fm_a_c * fm_b_c;
  end
`endif

  // Single-cycle ALU on forwarded operands
  always_comb begin
    shamt_c = s2data_n[SHAMT_W-1:0];
    alu_c   = '0;
    case (alusel)
      OP_ADD: alu_c = s1data_n + s2data_n;
      OP_SUB: alu_c = s1data_n - s2data_n;
      OP_SLL: alu_c = s1data_n << shamt_c;
      OP_SRL: alu_c = s1data_n >> shamt_c;
      OP_SRA: alu_c = $signed(s1data_n) >>> shamt_c;
      OP_XOR: alu_c = s1data_n ^ s2data_n;
      OP_OR:  alu_c = s1data_n | s2data_n;
      OP_AND: alu_c = s1data_n & s2data_n;
      OP_ULT: alu_c = {{(XLEN-1){1'b0}}, (s1data_n < s2data_n)};
      OP_SLT: alu_c = {{(XLEN-1){1'b0}}, ($signed(s1data_n) < $signed(s2data_n))};
`ifdef EX_FASTMUL_EN
      OP_MUL:                        alu_c = fm_prod_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  alu_c = fm_prod_c[PROD_W-1:XLEN];
`endif
      default: alu_c = '0;
    endcase
  end

  // Iterative step datapath and sign-corrected final result
  always_comb begin
    is_div_q_c = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    mul_sum_c  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    rem_sh_c   = {acc_q, lo_q[XLEN-1]};
    ge_c       = rem_sh_c >= {1'b0, opb_q};
    prod_fix_c = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    case (op_q)
      OP_MUL:                       md_res_c = prod_fix_c[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: md_res_c = prod_fix_c[PROD_W-1:XLEN];
      OP_DIV, OP_DIVU:              md_res_c = neg_q ? -lo_q : lo_q;
      OP_REM, OP_REMU:              md_res_c = neg_q ? -acc_q : acc_q;
      default:                      md_res_c = '0;
    endcase
  end

  // Next-state and output logic of the multiply/divide FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    op_d      = op_q;
    rd_d      = rd_q;
    regwe_d   = regwe_q;
    neg_d     = neg_q;
    stallreq  = 1'b0;
    out_valid = 1'b0;
    regwe_o   = 1'b0;
    rd_o      = rd;
    result    = alu_c;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_md_c) begin
          stallreq = 1'b1;
          op_d     = alusel;
          rd_d     = rd;
          regwe_d  = regwe;
          if (div_zero_c) begin
            acc_d   = s1data_n;
            lo_d    = '1;
            neg_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_DONE;
          end else if (div_ovf_c) begin
            acc_d   = '0;
            lo_d    = s1data_n;
            neg_d   = 1'b0;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            acc_d   = '0;
            lo_d    = abs_a_c;
            opb_d   = abs_b_c;
            neg_d   = neg_start_c;
            cnt_d   = CNT_W'(XLEN);
            state_d = S_BUSY;
          end
        end else begin
          out_valid = in_valid;
          regwe_o   = in_valid & regwe;
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        rd_o     = rd_q;
        result   = '0;
        if (is_div_q_c) begin
          acc_d = ge_c ? XLEN'(rem_sh_c - {1'b0, opb_q}) : rem_sh_c[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], ge_c};
        end else begin
          acc_d = mul_sum_c[XLEN:1];
          lo_d  = {mul_sum_c[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        regwe_o   = regwe_q;
        rd_o      = rd_q;
        result    = md_res_c;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      stallreq  = 1'b0;
      out_valid = 1'b0;
      regwe_o   = 1'b0;
    end
    if (!rst) begin
      stallreq  = 1'b0;
      out_valid = 1'b0;
      regwe_o   = 1'b0;
      rd_o      = '0;
      result    = '0;
    end
  end

  assign busy = (state_q != S_IDLE);

  // State and latched-operand registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      regwe_q <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      regwe_q <= regwe_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv (XLEN=32) with hand-computed results.
module tb_ex_muldiv;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ALUSEL_W  = 5;
  localparam int unsigned REGADDR_W = 5;
`ifdef EX_FASTMUL_EN
  localparam int MUL_STALLS = 0;
`else
  localparam int MUL_STALLS = 33;
`endif

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SRL = 5'd3, SRA = 5'd4;
  localparam logic [4:0] XOR = 5'd5, ULT = 5'd8, SLT = 5'd9;
  localparam logic [4:0] MUL = 5'd10, MULH = 5'd11, MULHSU = 5'd12, MULHU = 5'd13;
  localparam logic [4:0] DIV = 5'd14, DIVU = 5'd15, REM = 5'd16, REMU = 5'd17;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 in_valid = 1'b0;
  logic [ALUSEL_W-1:0]  alusel = '0;
  logic [XLEN-1:0]      s1data = '0, s2data = '0;
  logic                 fromreg1 = 1'b0, fromreg2 = 1'b0;
  logic [REGADDR_W-1:0] reg1addr = '0, reg2addr = '0, rd = '0;
  logic                 regwe = 1'b0;
  logic [REGADDR_W-1:0] ex_mem_rd = '0, wb_rd = '0;
  logic                 ex_mem_regwe = 1'b0, wb_regwe = 1'b0;
  logic [XLEN-1:0]      ex_mem_wbdata = '0, wb_wbdata = '0;
  logic                 stallreq, out_valid, regwe_o, busy;
  logic [REGADDR_W-1:0] rd_o;
  logic [XLEN-1:0]      result, s1data_n, s2data_n;

  int n_chk  = 0;
  int n_fail = 0;

  ex_muldiv #(.XLEN(XLEN), .ALUSEL_W(ALUSEL_W), .REGADDR_W(REGADDR_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .alusel(alusel),
    .s1data(s1data), .s2data(s2data), .fromreg1(fromreg1), .fromreg2(fromreg2),
    .reg1addr(reg1addr), .reg2addr(reg2addr), .rd(rd), .regwe(regwe),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwe(ex_mem_regwe), .ex_mem_wbdata(ex_mem_wbdata),
    .wb_rd(wb_rd), .wb_regwe(wb_regwe), .wb_wbdata(wb_wbdata),
    .stallreq(stallreq), .out_valid(out_valid), .rd_o(rd_o), .regwe_o(regwe_o),
    .result(result), .busy(busy), .s1data_n(s1data_n), .s2data_n(s2data_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One single-cycle op without forwarding; result checked in the same cycle
  task automatic run_alu(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; alusel = op; s1data = a; s2data = b;
    fromreg1 = 1'b0; fromreg2 = 1'b0; rd = 5'd5; regwe = 1'b1;
    #2;
    check({tag, ".result"}, 64'(result), 64'(exp));
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".stallreq"}, 64'(stallreq), 64'd0);
  endtask

  // One multi-cycle op: count stall cycles, then check the release cycle
  task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int stalls;
    bit early;
    stalls = 0;
    early  = 1'b0;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b1; alusel = op; s1data = a; s2data = b;
    fromreg1 = 1'b0; fromreg2 = 1'b0; rd = 5'd9; regwe = 1'b1;
    #2;
    while (stallreq && stalls < 100) begin
      if (out_valid || regwe_o) early = 1'b1;
      stalls++;
      @(negedge clk);
      #2;
    end
    check({tag, ".stalls"}, 64'(stalls), 64'(exp_stalls));
    check({tag, ".valid_during_stall"}, 64'(early), 64'd0);
    check({tag, ".result"}, 64'(result), 64'(exp));
    check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    check({tag, ".regwe_o"}, 64'(regwe_o), 64'd1);
    check({tag, ".rd_o"}, 64'(rd_o), 64'd9);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset held with a live instruction present: all outputs must stay zero
    in_valid = 1'b1; alusel = ADD; s1data = 32'd5; s2data = 32'd7; rd = 5'd5; regwe = 1'b1;
    #3;
    check("rst.stallreq", 64'(stallreq), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.regwe_o", 64'(regwe_o), 64'd0);
    check("rst.rd_o", 64'(rd_o), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Forwarding: EX/MEM wins over WB on operand 1
    @(negedge clk);
    in_valid = 1'b1; alusel = ADD; s1data = 32'd5; s2data = 32'd7; rd = 5'd4; regwe = 1'b1;
    fromreg1 = 1'b1; reg1addr = 5'd3; fromreg2 = 1'b0; reg2addr = 5'd0;
    ex_mem_rd = 5'd3; ex_mem_regwe = 1'b1; ex_mem_wbdata = 32'd100;
    wb_rd = 5'd3; wb_regwe = 1'b1; wb_wbdata = 32'd200;
    #2;
    check("fwd_exmem.result", 64'(result), 64'd107);
    check("fwd_exmem.s1data_n", 64'(s1data_n), 64'd100);
    check("fwd_exmem.stallreq", 64'(stallreq), 64'd0);
    check("fwd_exmem.out_valid", 64'(out_valid), 64'd1);
    check("fwd_exmem.regwe_o", 64'(regwe_o), 64'd1);
    check("fwd_exmem.rd_o", 64'(rd_o), 64'd4);

    // WB source feeds operand 2 while EX/MEM still feeds operand 1
    @(negedge clk);
    fromreg2 = 1'b1; reg2addr = 5'd6; wb_rd = 5'd6; wb_wbdata = 32'd50;
    #2;
    check("fwd_wb.s2data_n", 64'(s2data_n), 64'd50);
    check("fwd_wb.result", 64'(result), 64'd150);

    // Register x0 never forwards
    @(negedge clk);
    reg1addr = 5'd0; ex_mem_rd = 5'd0; reg2addr = 5'd0; wb_rd = 5'd0;
    #2;
    check("fwd_x0.result", 64'(result), 64'd12);
    @(negedge clk);
    ex_mem_regwe = 1'b0; wb_regwe = 1'b0;

    run_alu("sub", SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_alu("sll", SLL, 32'd1, 32'd31, 32'h8000_0000);
    run_alu("srl", SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_alu("sra_shamt", SRA, 32'h8000_0000, 32'd33, 32'hC000_0000);
    run_alu("xor", XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
    run_alu("slt", SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    run_alu("ult", ULT, 32'hFFFF_FFFF, 32'd1, 32'd0);
    run_alu("badop", 5'd20, 32'd3, 32'd4, 32'd0);

    run_md("div_neg", DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    run_md("rem_neg", REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    run_md("rem_pos_dvd", REM, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    run_md("divu_by0", DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("remu_by0", REMU, 32'h1234, 32'd0, 32'h1234, 1);
    run_md("div_by0", DIV, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_md("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_md("mulhu_max", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_STALLS);
    run_md("mul_max", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, MUL_STALLS);
    run_md("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, MUL_STALLS);
    run_md("mulh_neg", MULH, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, MUL_STALLS);
    run_md("mul_neg", MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, MUL_STALLS);
    run_md("mul_small", MUL, 32'd6, 32'd7, 32'd42, MUL_STALLS);

    // Flush in BUSY cycle 10 of a divide
    @(negedge clk);
    in_valid = 1'b1; alusel = DIV; s1data = 32'd1000; s2data = 32'd7; rd = 5'd9; regwe = 1'b1;
    #2;
    check("flush.issue_stall", 64'(stallreq), 64'd1);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #2;
    check("flush.stallreq", 64'(stallreq), 64'd0);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #2;
    check("flush.busy_after", 64'(busy), 64'd0);
    check("flush.stall_after", 64'(stallreq), 64'd0);
    run_alu("flush_add", ADD, 32'd2, 32'd3, 32'd5);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1; alusel = DIVU; s1data = 32'd100; s2data = 32'd7; rd = 5'd9; regwe = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid.stallreq", 64'(stallreq), 64'd0);
    check("rst_mid.out_valid", 64'(out_valid), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.regwe_o", 64'(regwe_o), 64'd0);
    check("rst_mid.rd_o", 64'(rd_o), 64'd0);
    check("rst_mid.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    run_md("divu_post_rst", DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
